// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path types and constants for the hazard control unit.
// Holds the forwarding-select encoding, FSM state type and forwarding decode helper.
package cpu_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam int DEF_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  // A load in EX has no result yet, so its match must not select the EX path.
  function automatic logic [1:0] fwd_decode(input logic ex_hit,
                                            input logic mem_hit,
                                            input logic ex_load);
    if (ex_hit) begin
      return ex_load ? FWD_REG : FWD_EX;
    end
    if (mem_hit) begin
      return FWD_MEM;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: forwarding selects, stall/flush enables, halt latch
// and saturating hazard statistics.
//
// state  | meaning
// RUN    | normal issue; decodes branch flush, load-use stall, halt request
// STALL  | extra load-use stall cycles while the slow load completes
// HALTED | pipeline frozen until reset
module hazard_ctrl_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r1_ex_related,
  input  logic             r1_mem_related,
  input  logic             r2_ex_related,
  input  logic             r2_mem_related,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             halt_req,
  output logic [1:0]       fwd_r1_sel,
  output logic [1:0]       fwd_r2_sel,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 1);

  hz_state_t  r_state;
  hz_state_t  w_state_nxt;
  logic [3:0] r_remaining;
  logic [3:0] w_remaining_nxt;
  logic       w_lu;
  logic [1:0] w_dec_r1;
  logic [1:0] w_dec_r2;
  logic       w_stall_inc;
  logic       w_flush_inc;
  logic       w_fwd_inc;

  assign w_lu     = ex_is_load & (r1_ex_related | r2_ex_related);
  assign w_dec_r1 = fwd_decode(r1_ex_related, r1_mem_related, ex_is_load);
  assign w_dec_r2 = fwd_decode(r2_ex_related, r2_mem_related, ex_is_load);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    case (r_state)
      RUN: begin
        if (ex_branch_taken) begin
          w_state_nxt = RUN;
        end else if (w_lu) begin
          if (STALL_CYCLES > 1) begin
            w_state_nxt     = STALL;
            w_remaining_nxt = STALL_INIT;
          end
        end else if (halt_req) begin
          w_state_nxt = HALTED;
        end
      end
      STALL: begin
        // remaining == 1 is the terminal count: this is the last stall cycle
        if (ex_branch_taken || (r_remaining == 4'd1)) begin
          w_state_nxt     = RUN;
          w_remaining_nxt = '0;
        end else begin
          w_remaining_nxt = r_remaining - 4'd1;
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt     = RUN;
        w_remaining_nxt = '0;
      end
    endcase
  end

  // While rst is high the outputs look like an idle RUN cycle.
  always_comb begin
    fwd_r1_sel  = FWD_REG;
    fwd_r2_sel  = FWD_REG;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN, STALL: begin
          fwd_r1_sel = w_dec_r1;
          fwd_r2_sel = w_dec_r2;
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            w_flush_inc = 1'b1;
          end else if (w_lu || (r_state == STALL)) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
            w_stall_inc = 1'b1;
          end
        end
        HALTED: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        default: begin
          pc_en = 1'b1;
        end
      endcase
    end
  end

  assign w_fwd_inc = (fwd_r1_sel != FWD_REG) | (fwd_r2_sel != FWD_REG);
  assign halted    = (r_state == HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk (clk),
    .i_clr (rst),
    .i_inc (w_stall_inc),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fwd_cnt (
    .i_clk (clk),
    .i_clr (rst),
    .i_inc (w_fwd_inc),
    .o_cnt (fwd_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk (clk),
    .i_clr (rst),
    .i_inc (w_flush_inc),
    .o_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (1-cycle stall / 32-bit counters and
// 3-cycle stall / 4-bit counters) sharing stimulus, checked against a cycle model.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, r1e, r1m, r2e, r2m, ld, br, hlt;

  logic [1:0]  a_s1, a_s2, b_s1, b_s2;
  logic        a_pc, a_if, a_ifl, a_idx, a_h;
  logic        b_pc, b_if, b_ifl, b_idx, b_h;
  logic [31:0] a_st, a_fw, a_fl;
  logic [3:0]  b_st, b_fw, b_fl;

  hazard_ctrl_unit #(.STALL_CYCLES(1), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst),
    .r1_ex_related(r1e), .r1_mem_related(r1m),
    .r2_ex_related(r2e), .r2_mem_related(r2m),
    .ex_is_load(ld), .ex_branch_taken(br), .halt_req(hlt),
    .fwd_r1_sel(a_s1), .fwd_r2_sel(a_s2),
    .pc_en(a_pc), .ifid_en(a_if), .ifid_flush(a_ifl), .idex_flush(a_idx),
    .halted(a_h), .stall_cnt(a_st), .fwd_cnt(a_fw), .flush_cnt(a_fl)
  );

  hazard_ctrl_unit #(.STALL_CYCLES(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .r1_ex_related(r1e), .r1_mem_related(r1m),
    .r2_ex_related(r2e), .r2_mem_related(r2m),
    .ex_is_load(ld), .ex_branch_taken(br), .halt_req(hlt),
    .fwd_r1_sel(b_s1), .fwd_r2_sel(b_s2),
    .pc_en(b_pc), .ifid_en(b_if), .ifid_flush(b_ifl), .idex_flush(b_idx),
    .halted(b_h), .stall_cnt(b_st), .fwd_cnt(b_fw), .flush_cnt(b_fl)
  );

  wire [8:0] a_out = {a_s1, a_s2, a_pc, a_if, a_ifl, a_idx, a_h};
  wire [8:0] b_out = {b_s1, b_s2, b_pc, b_if, b_ifl, b_idx, b_h};

  int n_chk = 0;
  int n_err = 0;

  // Reference model: "owed" is how many further stall cycles the pipeline still owes.
  int     sc[2]   = '{1, 3};
  longint cmax[2] = '{64'hFFFF_FFFF, 64'd15};
  int     m_halted[2];
  int     m_owed[2];
  longint m_st[2], m_fw[2], m_fl[2];
  logic [8:0] e_out[2];
  int     e_kind[2];
  logic   e_fwd[2];

  typedef struct {
    logic [7:0] in_v;   // {rst, r1e, r1m, r2e, r2m, ld, br, hlt}
    logic [8:0] out_v;  // {s1, s2, pc_en, ifid_en, ifid_flush, idex_flush, halted}
    int         st;
    int         fw;
    int         fl;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_sel(input logic ex, input logic mem, input logic load);
    if (ex && load) return 2'd0;
    if (ex) return 2'd1;
    if (mem) return 2'd2;
    return 2'd0;
  endfunction

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic predict();
    for (int k = 0; k < 2; k++) begin
      logic [1:0] s1, s2;
      logic pc, ife, ifl, idx, lu;
      int kind;
      s1 = 2'd0; s2 = 2'd0; pc = 1'b1; ife = 1'b1; ifl = 1'b0; idx = 1'b0;
      lu = ld && (r1e || r2e);
      if (rst) begin
        kind = 6;
      end else if (m_halted[k] != 0) begin
        pc = 1'b0; ife = 1'b0; idx = 1'b1; kind = 5;
      end else begin
        s1 = ref_sel(r1e, r1m, ld);
        s2 = ref_sel(r2e, r2m, ld);
        if (br) begin
          ifl = 1'b1; idx = 1'b1; kind = 1;
        end else if (m_owed[k] > 0) begin
          pc = 1'b0; ife = 1'b0; idx = 1'b1; kind = 2;
        end else if (lu) begin
          pc = 1'b0; ife = 1'b0; idx = 1'b1; kind = 3;
        end else begin
          kind = hlt ? 4 : 0;
        end
      end
      e_out[k]  = {s1, s2, pc, ife, ifl, idx, (m_halted[k] != 0)};
      e_kind[k] = kind;
      e_fwd[k]  = (s1 != 2'd0) || (s2 != 2'd0);
    end
  endtask

  task automatic commit();
    for (int k = 0; k < 2; k++) begin
      if (e_kind[k] == 6) begin
        m_halted[k] = 0; m_owed[k] = 0; m_st[k] = 0; m_fw[k] = 0; m_fl[k] = 0;
      end else if (e_kind[k] != 5) begin
        if (e_fwd[k]) m_fw[k] = sat_inc(m_fw[k], cmax[k]);
        case (e_kind[k])
          1: begin m_fl[k] = sat_inc(m_fl[k], cmax[k]); m_owed[k] = 0; end
          2: begin m_st[k] = sat_inc(m_st[k], cmax[k]); m_owed[k] = m_owed[k] - 1; end
          3: begin m_st[k] = sat_inc(m_st[k], cmax[k]); m_owed[k] = sc[k] - 1; end
          4: m_halted[k] = 1;
          default: ;
        endcase
      end
    end
  endtask

  task automatic step_check();
    #3;
    predict();
    chk("a_outputs", longint'(a_out), longint'(e_out[0]));
    chk("a_stall_cnt", longint'(a_st), m_st[0]);
    chk("a_fwd_cnt", longint'(a_fw), m_fw[0]);
    chk("a_flush_cnt", longint'(a_fl), m_fl[0]);
    chk("b_outputs", longint'(b_out), longint'(e_out[1]));
    chk("b_stall_cnt", longint'(b_st), m_st[1]);
    chk("b_fwd_cnt", longint'(b_fw), m_fw[1]);
    chk("b_flush_cnt", longint'(b_fl), m_fl[1]);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic set_in(input logic [7:0] v);
    {rst, r1e, r1m, r2e, r2m, ld, br, hlt} = v;
  endtask

  initial begin
    logic [5:0] pc_hist;
    int b_stalls;

    tbl[0] = '{8'b1_1_0_0_0_1_1_0, 9'b00_00_1_1_0_0_0, 0, 0, 0};
    tbl[1] = '{8'b0_1_0_0_0_0_0_0, 9'b01_00_1_1_0_0_0, 0, 0, 0};
    tbl[2] = '{8'b0_0_0_1_1_0_0_0, 9'b00_01_1_1_0_0_0, 0, 1, 0};
    tbl[3] = '{8'b0_0_0_0_1_0_0_0, 9'b00_10_1_1_0_0_0, 0, 2, 0};
    tbl[4] = '{8'b0_1_0_0_0_1_0_0, 9'b00_00_0_0_0_1_0, 0, 3, 0};
    tbl[5] = '{8'b0_0_1_0_0_0_0_0, 9'b10_00_1_1_0_0_0, 1, 3, 0};
    tbl[6] = '{8'b0_1_0_0_0_1_1_1, 9'b00_00_1_1_1_1_0, 1, 4, 0};
    tbl[7] = '{8'b0_0_0_0_0_0_0_0, 9'b00_00_1_1_0_0_0, 1, 4, 1};
    tbl[8] = '{8'b0_0_0_0_0_0_0_1, 9'b00_00_1_1_0_0_0, 1, 4, 1};
    tbl[9] = '{8'b0_1_0_0_0_0_0_0, 9'b00_00_0_0_0_1_1, 1, 4, 1};

    for (int k = 0; k < 2; k++) begin
      m_halted[k] = 0; m_owed[k] = 0; m_st[k] = 0; m_fw[k] = 0; m_fl[k] = 0;
    end
    set_in(8'b1000_0000);
    @(posedge clk);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].in_v);
      step_check();
      chk($sformatf("vec%0d_outputs", i), longint'(a_out), longint'(tbl[i].out_v));
      chk($sformatf("vec%0d_stall_cnt", i), longint'(a_st), longint'(tbl[i].st));
      chk($sformatf("vec%0d_fwd_cnt", i), longint'(a_fw), longint'(tbl[i].fw));
      chk($sformatf("vec%0d_flush_cnt", i), longint'(a_fl), longint'(tbl[i].fl));
      advance();
    end

    for (int i = 0; i < 10; i++) begin
      set_in({1'b0, 7'($urandom)});
      step_check();
      chk("halted_pc_en", longint'(a_pc), 0);
      chk("halted_flag", longint'(a_h), 1);
      advance();
    end
    set_in(8'b1000_0000);
    step_check();
    advance();
    set_in(8'b0000_0000);
    step_check();
    chk("post_rst_halted", longint'(a_h), 0);
    chk("post_rst_stall_cnt", longint'(a_st), 0);
    chk("post_rst_fwd_cnt", longint'(a_fw), 0);
    chk("post_rst_flush_cnt", longint'(a_fl), 0);
    advance();

    pc_hist  = '0;
    b_stalls = 0;
    for (int i = 0; i < 6; i++) begin
      set_in((i == 0) ? 8'b0100_0100 : 8'b0000_0000);
      step_check();
      pc_hist[i] = b_pc;
      if (!b_pc) b_stalls++;
      advance();
    end
    chk("b_stall_window", longint'(pc_hist), longint'(6'b111000));
    chk("b_stall_cycles", longint'(b_stalls), 3);
    set_in(8'b0000_0000);
    step_check();
    chk("b_stall_cnt_3", longint'(b_st), 3);
    advance();

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) begin
        set_in((i == 0) ? 8'b0001_0100 : 8'b0000_0000);
        step_check();
        advance();
      end
      if (n == 4) begin
        set_in(8'b0000_0000);
        step_check();
        chk("b_stall_cnt_sat", longint'(b_st), 15);
        advance();
      end
    end
    set_in(8'b0000_0000);
    step_check();
    chk("b_stall_cnt_hold", longint'(b_st), 15);
    advance();

    for (int i = 0; i < 600; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      v[7] = (m_halted[0] != 0 || m_halted[1] != 0) ? ($urandom_range(0, 3) == 0)
                                                     : ($urandom_range(0, 49) == 0);
      v[1] = ($urandom_range(0, 5) == 0);
      v[0] = ($urandom_range(0, 29) == 0);
      set_in(v);
      step_check();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
